mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Memory-side responder for the execution-stage memory request interface (req_valid/grant/addr/we/data/data_valid), plus a read-only fetch port.
- Arbitrates the two requesters round-robin and services one access at a time from an internal word-addressed data array with fixed, parameterised access latency.
- Sits between the execution unit's load/store path, the fetch stage and on-chip memory.

Parameters:
- ADDR_WIDTH, 32, byte-address width of both ports.
- DATA_WIDTH, 32, word width.
- MEM_DEPTH, 1024, number of words in the internal array (power of two).
- MEM_LATENCY, 2, cycles from grant to data_valid; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- exe_req_valid  input  1  execution-unit request; level, held until exe_data_valid.
- exe_addr  input  ADDR_WIDTH  byte address; word index = addr[log2(MEM_DEPTH)+1:2].
- exe_we  input  1  1 = store, 0 = load.
- exe_data  inout  DATA_WIDTH  store data in; load data out.
- exe_grant  output  1  one-cycle pulse: request accepted.
- exe_data_valid  output  1  one-cycle pulse: load data valid / store done.
- if_req_valid  input  1  fetch read request; level, held until if_data_valid.
- if_addr  input  ADDR_WIDTH  fetch byte address.
- if_grant  output  1  one-cycle pulse: fetch accepted.
- if_data  output  DATA_WIDTH  fetch read data; registered, holds last value.
- if_data_valid  output  1  one-cycle pulse: if_data valid.
- addr_err  output  1  one-cycle pulse with data_valid when the word index is >= MEM_DEPTH.

Behaviour:
- Reset (reset=0, async): state=IDLE; all grant, data_valid and addr_err outputs 0; if_data=0; exe_data high-Z; last_winner=FETCH, so exe wins the first tie. The array is not cleared.
- Reset mid-access aborts it: no data_valid, no write is committed, exe_data released to Z immediately.
- FSM states: IDLE, WAIT, RESP.
- IDLE, at an edge with any request:
  - Pick the winner (round-robin below).
  - Latch port, word index, we, and store data (exe_data sampled at this edge).
  - Assert that port's grant for the next cycle.
  - cnt = MEM_LATENCY-1; go to WAIT.
- WAIT, each edge:
  - Grant returns to 0.
  - If cnt!=0: cnt--.
  - If cnt==0: perform the access; assert that port's data_valid for one cycle; go to RESP.
- RESP, next edge: data_valid=0; go to IDLE. A request still high in IDLE is a new request, so initiators must drop req_valid in the data_valid cycle.
- Latency: request sampled at edge E0 → grant high E0..E1; data_valid high from edge E0+MEM_LATENCY for one cycle. Minimum spacing between grants is MEM_LATENCY+2 cycles.
- Round-robin:
  - Only one port requesting → it wins.
  - Both requesting → the port that is not last_winner wins.
  - last_winner updates on every grant.
- Requests arriving during WAIT/RESP are not dropped (level-sensitive); they are serviced from IDLE.
- Loads:
  - Read array[index] at the access edge.
  - Exe port: exe_data driven with read data only while exe_data_valid=1 and the latched we=0; Z in all other cycles.
  - Fetch port: if_data updated with read data.
- Stores: array[index] <= latched store data at the access edge; exe_data_valid pulses as completion ack; exe_data stays Z. Fetch never writes.
- Address rules:
  - addr[1:0] ignored (word access only).
  - Index >= MEM_DEPTH: read returns 0, write dropped, addr_err pulses with data_valid. Not reachable when ADDR_WIDTH maps exactly onto MEM_DEPTH.
- At most one grant and one data_valid asserted in any cycle.

Test Plan:
- Reset released; exe store addr 0x10, data 0xDEADBEEF, MEM_LATENCY=2 → exe_grant 1 cycle after request edge, exe_data_valid exactly 2 cycles after grant, exe_data Z throughout.
- Exe load 0x10 after the above → exe_data_valid pulse with exe_data=0xDEADBEEF in that cycle only, Z before and after.
- Fetch and exe request in the same IDLE cycle after reset → exe granted first, fetch granted after exe's RESP. Repeat with both held → grants alternate exe, fetch, exe.
- Fetch read 0x10 while exe store 0x10=0x12345678 wins first → if_data=0x12345678 (write ordered before read).
- Assert reset during WAIT of a store to 0x20 (old value 0xA5A5A5A5) → no data_valid, FSM back to IDLE, later load 0x20 returns 0xA5A5A5A5.
- MEM_DEPTH=1024, ADDR_WIDTH=32, exe load 0x1000 → exe_data=0, addr_err and exe_data_valid pulse together; store to 0x1000 leaves array unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Memory-side responder shared by the execution unit's load/store port and
//   the read-only fetch port. Requests from the two ports are arbitrated
//   round-robin, and one access at a time is serviced from an internal
//   word-addressed array. Every access has the fixed latency MEM_LATENCY.
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous reset, active low
//   exe_req_valid   exe request, level, held until exe_data_valid
//   exe_addr        exe byte address (addr[1:0] ignored)
//   exe_we          1 = store, 0 = load
//   exe_data        inout: store data in; load data out during exe_data_valid
//   exe_grant       one-cycle pulse, exe request accepted
//   exe_data_valid  one-cycle pulse, load data valid / store done
//   if_req_valid    fetch read request, level, held until if_data_valid
//   if_addr         fetch byte address (addr[1:0] ignored)
//   if_grant        one-cycle pulse, fetch accepted
//   if_data         fetch read data, registered, holds its last value
//   if_data_valid   one-cycle pulse, if_data valid
//   addr_err        pulses with data_valid when the word index >= MEM_DEPTH
module mem_arbiter #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int MEM_LATENCY = 2      // 1..15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  exe_req_valid,
  input  logic [ADDR_WIDTH-1:0] exe_addr,
  input  logic                  exe_we,
  inout  wire  [DATA_WIDTH-1:0] exe_data,
  output logic                  exe_grant,
  output logic                  exe_data_valid,
  input  logic                  if_req_valid,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_grant,
  output logic [DATA_WIDTH-1:0] if_data,
  output logic                  if_data_valid,
  output logic                  addr_err
);

  localparam int IDX_W   = $clog2(MEM_DEPTH);
  localparam int WADDR_W = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic [3:0]            cnt;
  logic                  last_fetch;   // 1 when fetch took the most recent grant
  logic                  lat_fetch;    // port owning the current access
  logic                  lat_we;
  logic [WADDR_W-1:0]    lat_widx;     // full word index, range-checked below
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [DATA_WIDTH-1:0] exe_rdata;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  start, access, exe_wins, lat_err;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Byte-lane bits carry no information for word accesses.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{exe_addr[1:0], if_addr[1:0]};

  // On a tie the port that did not win last time takes the grant.
  assign exe_wins = exe_req_valid && (!if_req_valid || last_fetch);

  // The full word index is kept, so an index past the array is detectable.
  // The compare is one bit wider so that MEM_DEPTH never truncates to zero
  // when the address maps exactly onto the array.
  assign lat_err = ({1'b0, lat_widx} >= (WADDR_W + 1)'(MEM_DEPTH));
  assign rd_word = lat_err ? '0 : mem[lat_widx[IDX_W-1:0]];

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    access    = 1'b0;
    case (state)
      IDLE: begin
        if (exe_req_valid || if_req_valid) begin
          start     = 1'b1;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          access    = 1'b1;
          state_nxt = RESP;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      cnt            <= 4'd0;
      last_fetch     <= 1'b1;
      lat_fetch      <= 1'b0;
      lat_we         <= 1'b0;
      exe_grant      <= 1'b0;
      if_grant       <= 1'b0;
      exe_data_valid <= 1'b0;
      if_data_valid  <= 1'b0;
      addr_err       <= 1'b0;
      if_data        <= '0;
    end else begin
      state          <= state_nxt;
      exe_grant      <= start && exe_wins;
      if_grant       <= start && !exe_wins;
      exe_data_valid <= access && !lat_fetch;
      if_data_valid  <= access && lat_fetch;
      addr_err       <= access && lat_err;
      if (start) begin
        cnt        <= 4'(MEM_LATENCY - 1);
        last_fetch <= !exe_wins;
        lat_fetch  <= !exe_wins;
        lat_we     <= exe_wins && exe_we;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (access && lat_fetch) begin
        if_data <= rd_word;
      end
    end
  end

  // Address, store data and exe read data need no reset: they are only
  // consumed while the control path qualifies them.
  always_ff @(posedge clk) begin
    if (start) begin
      lat_widx  <= exe_wins ? exe_addr[ADDR_WIDTH-1:2] : if_addr[ADDR_WIDTH-1:2];
      lat_wdata <= exe_data;
    end
    if (access) begin
      exe_rdata <= rd_word;
    end
  end

  // An access aborted by reset never reaches the access edge (state is
  // forced to IDLE), so no write can be committed for it.
  always_ff @(posedge clk) begin
    if (access && lat_we && !lat_err) begin
      mem[lat_widx[IDX_W-1:0]] <= lat_wdata;
    end
  end

  // The bus is driven only during the load response cycle; exe_data_valid
  // is reset asynchronously, so reset releases it at once.
  assign exe_data = (exe_data_valid && !lat_we) ? exe_rdata : 'z;

endmodule
